// File: rtl/ula_arbitro.sv
// Two-requester front end for a shared ula with a two-register latency.
// Grants round-robin, latches the winner's operands, sequences the four-state
// LOAD/EXEC/CAPT pipeline and returns the result with a one-cycle done pulse.
module ula_arbitro (
    input  logic       ck,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res,
    output logic [7:0] ula_A,
    output logic [7:0] ula_B,
    output logic [2:0] ula_op,
    input  logic [7:0] ula_S,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StCapt} state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic [7:0] res_q;
    logic       gnt_q;   // requester owning the in-flight operation
    logic       last_q;  // requester granted most recently
    logic       done0_q, done1_q;
    logic       any_req;
    logic       win;
    logic       grant;

    // Round-robin winner: a tie goes to the requester not granted last.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 && req1) ? ~last_q : req1;
        grant   = (state_q == StIdle) && any_req;
    end

    // State register.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only IDLE waits, the rest advance unconditionally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StLoad;
            StLoad:  state_d = StExec;
            StExec:  state_d = StCapt;
            StCapt:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand latch on grant, result capture and done pulse at end of CAPT.
    always_ff @(posedge ck) begin
        if (rst) begin
            op_q    <= 3'b000;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= 8'h00;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (grant) begin
                gnt_q  <= win;
                last_q <= win;
                op_q   <= win ? op1 : op0;
                a_q    <= win ? a1 : a0;
                b_q    <= win ? b1 : b0;
            end
            if (state_q == StCapt) begin
                res_q   <= ula_S;
                done0_q <= ~gnt_q;
                done1_q <= gnt_q;
            end
        end
    end

    // Outputs: ack is the LOAD cycle of the owner; ula inputs come from the latch.
    always_comb begin
        ack0   = (state_q == StLoad) && !gnt_q;
        ack1   = (state_q == StLoad) && gnt_q;
        busy   = (state_q != StIdle);
        done0  = done0_q;
        done1  = done1_q;
        res    = res_q;
        ula_A  = a_q;
        ula_B  = b_q;
        ula_op = op_q;
    end

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with a behavioural two-register ula model.
module tb_ula_arbitro;

    logic       ck = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1, done0, done1, busy;
    logic [7:0] res, ula_A, ula_B, ula_S;
    logic [2:0] ula_op;

    int checks = 0;
    int errors = 0;

    ula_arbitro dut (
        .ck     (ck),
        .rst    (rst),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .done0  (done0),
        .done1  (done1),
        .res    (res),
        .ula_A  (ula_A),
        .ula_B  (ula_B),
        .ula_op (ula_op),
        .ula_S  (ula_S),
        .busy   (busy)
    );

    always #5 ck = ~ck;

    // ula model: free-running input registers, S register, combinational opcode.
    logic [7:0] ua_q, ub_q, us_q;
    function automatic logic [7:0] ula_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~a;
            3'd3:    return ~b;
            3'd4:    return (a == b) ? 8'h01 : 8'h00;
            3'd5:    return (a != b) ? 8'h01 : 8'h00;
            3'd6:    return (a > b) ? 8'h01 : 8'h00;
            default: return (a < b) ? 8'h01 : 8'h00;
        endcase
    endfunction
    always @(posedge ck) begin
        ua_q <= ula_A;
        ub_q <= ula_B;
        us_q <= ula_f(ua_q, ub_q, ula_op);
    end
    assign ula_S = us_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check_eq("rst_ack",  {30'd0, ack1, ack0}, 32'd0);
        check_eq("rst_done", {30'd0, done1, done0}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_res",  {24'd0, res}, 32'h00);
        check_eq("rst_ula",  {13'd0, ula_op, ula_A, ula_B}, 32'd0);
        rst = 1'b0;
    endtask

    // One isolated transaction; operands are scrambled right after ack.
    task automatic run_one(input logic who, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp);
        if (who) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        step();  // grant edge -> LOAD
        check_eq("ack_own",   who ? ack1 : ack0, 1'b1);
        check_eq("ack_other", who ? ack0 : ack1, 1'b0);
        check_eq("busy_load", busy, 1'b1);
        check_eq("ula_in",    {13'd0, ula_op, ula_A, ula_B}, {13'd0, op, a, b});
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; op0 = ~op; op1 = ~op;
        step();  // EXEC
        check_eq("ack_drop",  {30'd0, ack1, ack0}, 32'd0);
        check_eq("busy_exec", busy, 1'b1);
        step();  // CAPT
        check_eq("busy_capt", busy, 1'b1);
        check_eq("ula_hold",  {13'd0, ula_op, ula_A, ula_B}, {13'd0, op, a, b});
        check_eq("done_early", {30'd0, done1, done0}, 32'd0);
        step();  // IDLE, done pulse
        check_eq("done_own",   who ? done1 : done0, 1'b1);
        check_eq("done_other", who ? done0 : done1, 1'b0);
        check_eq("res",        {24'd0, res}, {24'd0, exp});
        check_eq("busy_idle",  busy, 1'b0);
        step();
        check_eq("done_pulse", {30'd0, done1, done0}, 32'd0);
        check_eq("res_hold",   {24'd0, res}, {24'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        step();
        do_reset();
        step();
        check_eq("idle_busy", busy, 1'b0);

        run_one(1'b0, 3'd0, 8'h05, 8'h03, 8'h08);
        run_one(1'b1, 3'd1, 8'h10, 8'h01, 8'h0F);
        run_one(1'b1, 3'd0, 8'hFF, 8'h01, 8'h00);
        run_one(1'b0, 3'd1, 8'h00, 8'h01, 8'hFF);
        run_one(1'b0, 3'd4, 8'h33, 8'h33, 8'h01);
        run_one(1'b1, 3'd5, 8'h33, 8'h33, 8'h00);
        run_one(1'b0, 3'd6, 8'h80, 8'h7F, 8'h01);
        run_one(1'b1, 3'd7, 8'h10, 8'h20, 8'h01);

        // Abort in EXEC: no done, everything back to reset values.
        req0 = 1'b1; op0 = 3'd0; a0 = 8'h20; b0 = 8'h22;
        step();
        check_eq("abort_ack", ack0, 1'b1);
        req0 = 1'b0;
        step();
        check_eq("abort_exec", busy, 1'b1);
        rst = 1'b1;
        step();
        check_eq("abort_out", {13'd0, ula_op, ula_A, ula_B}, 32'd0);
        check_eq("abort_res", {24'd0, res}, 32'd0);
        check_eq("abort_flags", {27'd0, busy, ack1, ack0, done1, done0}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("abort_nodone", {30'd0, done1, done0}, 32'd0);
        end
        run_one(1'b0, 3'd0, 8'h05, 8'h03, 8'h08);

        // Both requesting continuously from reset: grants alternate 0,1,0,1.
        do_reset();
        req0 = 1'b1; op0 = 3'd2; a0 = 8'hF0; b0 = 8'h55;
        req1 = 1'b1; op1 = 3'd3; a1 = 8'hAA; b1 = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rr_ack", {30'd0, ack1, ack0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            for (int c = 0; c < 2; c++) begin
                step();
                check_eq("rr_one_ack", {31'd0, ack0 & ack1}, 32'd0);
                check_eq("rr_no_done", {30'd0, done1, done0}, 32'd0);
            end
            step();
            check_eq("rr_done", {30'd0, done1, done0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("rr_res", {24'd0, res}, (i % 2 == 0) ? 32'h0F : 32'hF0);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
